// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the c_mem two-port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    ISSUE   = S_ISSUE,
    RD_WAIT = S_RD_WAIT,
    ACK     = S_ACK
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // One memory command as presented on the m_* bus.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } mem_cmd_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and c_mem bus.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_mask;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_request;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_w_data;
  logic [MASK_W-1:0] m_masking;
  logic              m_we_re;
  logic              m_valid;
  logic [DATA_W-1:0] m_r_data;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask, m_valid, m_r_data,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           m_request, m_address, m_w_data, m_masking, m_we_re
  );

  // Requesters plus memory side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask, m_valid, m_r_data,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           m_request, m_address, m_w_data, m_masking, m_we_re
  );
endinterface

// File: rtl/mem_arbiter_rr2.sv
// Combinational two-way round-robin pick between fetch (I) and data (D).
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);
  // Lone requester wins; on contention the port not served last wins.
  always_comb begin
    gnt_valid = req_i | req_d;
    if (req_i && req_d) gnt_id = ~last_grant;
    else if (req_d)     gnt_id = PORT_D;
    else                gnt_id = PORT_I;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared single-port c_mem: grants I or D round-robin,
// issues one m_request per transaction, times out missing read valids.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  localparam logic [3:0] TO = 4'(TIMEOUT);

  state_e     state, state_nxt;
  logic       last_grant, cur_port;
  logic       gnt_valid, gnt_id;
  logic       grant, rd_done, rd_to;
  logic [3:0] cnt, cnt_inc;
  mem_cmd_t   cmd_sel;

  assign cnt_inc = cnt + 4'd1;

  arb_rr2 u_rr (
    .req_i      (bus.i_req),
    .req_d      (bus.d_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Command of the port about to be granted; fetches are always unmasked reads.
  always_comb begin
    cmd_sel = '0;
    if (gnt_id == PORT_D) begin
      cmd_sel.we    = bus.d_we;
      cmd_sel.addr  = bus.d_addr;
      cmd_sel.wdata = bus.d_wdata;
      cmd_sel.mask  = bus.d_we ? bus.d_mask : '0;
    end else begin
      cmd_sel.addr  = bus.i_addr;
    end
  end

  // Next-state logic; m_we_re doubles as the "current transaction is a write" flag.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    rd_done   = 1'b0;
    rd_to     = 1'b0;
    case (state)
      IDLE: if (gnt_valid) begin
        grant     = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = bus.m_we_re ? ACK : RD_WAIT;
      RD_WAIT: begin
        if (bus.m_valid) begin
          rd_done   = 1'b1;
          state_nxt = ACK;
        end else if (cnt_inc == TO) begin
          rd_to     = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the granted command onto the memory bus; it holds until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= PORT_D;
      cur_port      <= PORT_I;
      bus.m_request <= 1'b0;
      bus.m_address <= '0;
      bus.m_w_data  <= '0;
      bus.m_masking <= '0;
      bus.m_we_re   <= 1'b0;
    end else begin
      bus.m_request <= grant;
      if (grant) begin
        last_grant    <= gnt_id;
        cur_port      <= gnt_id;
        bus.m_address <= cmd_sel.addr;
        bus.m_w_data  <= cmd_sel.wdata;
        bus.m_masking <= cmd_sel.mask;
        bus.m_we_re   <= cmd_sel.we;
      end
    end
  end

  // Read-valid timeout counter, cleared as the read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt <= '0;
    else if (state == ISSUE)                   cnt <= '0;
    else if (state == RD_WAIT && !bus.m_valid) cnt <= cnt_inc;
  end

  // Port responses: one-cycle ack/err in ACK; rdata only moves on a read completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_ack   <= 1'b0;
      bus.i_err   <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_ack   <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.d_rdata <= '0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.i_err <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.d_err <= 1'b0;
      if (state_nxt == ACK) begin
        if (cur_port == PORT_D) begin
          bus.d_ack <= 1'b1;
          bus.d_err <= rd_to;
          if (!bus.m_we_re) bus.d_rdata <= rd_done ? bus.m_r_data : '0;
        end else begin
          bus.i_ack <= 1'b1;
          bus.i_err <= rd_to;
          if (!bus.m_we_re) bus.i_rdata <= rd_done ? bus.m_r_data : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written reset, contention and stray-valid sequences.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: one-cycle read valid, masked byte writes, optional valid suppression.
  logic [31:0] mem [256];
  logic [31:0] wtmp;
  logic        mv = 1'b0;
  logic [31:0] mrd = '0;
  logic        suppress = 1'b0;
  logic        stray_v = 1'b0;
  logic [31:0] stray_d = '0;
  logic        pl_clr = 1'b0;
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign bus.m_valid  = mv | stray_v;
  assign bus.m_r_data = stray_v ? stray_d : mrd;

  always @(posedge clk) begin
    mv <= 1'b0;
    if (pl_clr) begin
      for (int a = 0; a < 256; a++) mem[a] = '0;
    end else if (pl_we) begin
      mem[pl_addr] = pl_data;
    end else if (bus.m_request) begin
      if (bus.m_we_re) begin
        wtmp = mem[bus.m_address];
        for (int b = 0; b < 4; b++)
          if (bus.m_masking[b]) wtmp[b*8 +: 8] = bus.m_w_data[b*8 +: 8];
        mem[bus.m_address] = wtmp;
      end else if (!suppress) begin
        mv  <= 1'b1;
        mrd <= mem[bus.m_address];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;   // 0 = I, 1 = D
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        sup;    // memory withholds m_valid
    int          lat;    // ack cycle, req first high in cycle 0
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  // Drive one transaction, watch it to its ack, compare against the vector.
  task automatic run_txn(input int idx, input vec_t v);
    int          lat, mk, nreq;
    logic        got, other, er, mw;
    logic [31:0] rd;
    logic [7:0]  ma;
    logic [3:0]  mm;
    lat = -1; mk = -1; nreq = 0; got = 1'b0; other = 1'b0;
    er = 1'b1; mw = 1'bx; rd = 32'hFFFF_FFFF; ma = 'x; mm = 'x;
    suppress = v.sup;
    if (v.port) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
      bus.d_wdata = v.wdata; bus.d_mask = v.mask;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.m_request) begin
        nreq++;
        if (mk < 0) begin
          mk = k; ma = bus.m_address; mw = bus.m_we_re; mm = bus.m_masking;
        end
      end
      if (v.port ? bus.d_ack : bus.i_ack) begin
        got = 1'b1; lat = k;
        rd = v.port ? bus.d_rdata : bus.i_rdata;
        er = v.port ? bus.d_err : bus.i_err;
      end
      if (v.port ? bus.i_ack : bus.d_ack) other = 1'b1;
      @(posedge clk); #1;
      if (got) break;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0; suppress = 1'b0;
    chk($sformatf("v%0d ack_cycle", idx), lat, v.lat);
    chk($sformatf("v%0d rdata", idx), rd, v.rdata);
    chk($sformatf("v%0d err", idx), {31'b0, er}, {31'b0, v.err});
    chk($sformatf("v%0d mreq_cycle", idx), mk, 1);
    chk($sformatf("v%0d mreq_count", idx), nreq, 1);
    chk($sformatf("v%0d m_address", idx), {24'b0, ma}, {24'b0, v.addr});
    chk($sformatf("v%0d m_we_re", idx), {31'b0, mw}, {31'b0, v.we});
    chk($sformatf("v%0d m_masking", idx), {28'b0, mm}, {28'b0, (v.port && v.we) ? v.mask : 4'h0});
    chk($sformatf("v%0d other_ack", idx), {31'b0, other}, 32'd0);
  endtask

  int          acks;
  int          ak[$];
  logic        ap[$];
  logic [31:0] ar[$];
  int          exp_k[4]      = '{3, 7, 11, 15};
  logic        exp_p[4]      = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] exp_d[4]      = '{32'hDEADBEEF, 32'h00BB00DD, 32'hDEADBEEF, 32'h00BB00DD};

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mask = '0;

    //                 port  we    addr   wdata         mask   sup  lat rdata         err
    vecs[0] = '{1'b0, 1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 3, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 1'b0, 2, 32'h00000000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 32'h0,        4'h0, 1'b0, 3, 32'h00BB00DD, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h30, 32'h11223344, 4'hF, 1'b0, 2, 32'h00BB00DD, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h30, 32'h0,        4'h0, 1'b0, 3, 32'h11223344, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 3, 32'hDEADBEEF, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 1'b1, 6, 32'h00000000, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'h30, 32'h0,        4'h0, 1'b0, 3, 32'h11223344, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 8'h20, 32'h0,        4'h0, 1'b0, 3, 32'h00BB00DD, 1'b0};

    // Reset and memory preload.
    pl_clr = 1'b1;
    @(posedge clk); #1;
    pl_clr = 1'b0;
    pl_we = 1'b1; pl_addr = 8'h10; pl_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    pl_we = 1'b0;
    chk("rst m_request", {31'b0, bus.m_request}, 32'd0);
    chk("rst i_ack", {31'b0, bus.i_ack}, 32'd0);
    chk("rst d_ack", {31'b0, bus.d_ack}, 32'd0);
    chk("rst errs", {30'b0, bus.i_err, bus.d_err}, 32'd0);
    chk("rst i_rdata", bus.i_rdata, 32'd0);
    chk("rst d_rdata", bus.d_rdata, 32'd0);
    chk("rst m_bus", {bus.m_address, bus.m_masking, bus.m_we_re}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

    // Reset while a read sits in RD_WAIT.
    suppress = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h10;
    bus.d_wdata = 32'hCAFEF00D; bus.d_mask = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("midrd m_address", {24'b0, bus.m_address}, 32'h10);
    rst_n = 1'b0;
    #1;
    chk("midrd rst d_ack", {31'b0, bus.d_ack}, 32'd0);
    chk("midrd rst i_rdata", bus.i_rdata, 32'd0);
    chk("midrd rst d_rdata", bus.d_rdata, 32'd0);
    chk("midrd rst m_address", {24'b0, bus.m_address}, 32'd0);
    chk("midrd rst m_w_data", bus.m_w_data, 32'd0);
    chk("midrd rst m_request", {31'b0, bus.m_request}, 32'd0);
    bus.d_req = 1'b0; suppress = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) acks++;
    end
    chk("midrd no_ack_after_reset", acks, 0);
    @(posedge clk); #1;

    // Contention with both requests held: I, D, I, D.
    bus.i_req = 1'b1; bus.i_addr = 8'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h20;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.i_ack) begin ak.push_back(k); ap.push_back(1'b0); ar.push_back(bus.i_rdata); end
      if (bus.d_ack) begin ak.push_back(k); ap.push_back(1'b1); ar.push_back(bus.d_rdata); end
      @(posedge clk); #1;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk("cont ack_count", ak.size(), 4);
    for (int j = 0; j < 4 && j < ak.size(); j++) begin
      chk($sformatf("cont%0d port", j), {31'b0, ap[j]}, {31'b0, exp_p[j]});
      chk($sformatf("cont%0d cycle", j), ak[j], exp_k[j]);
      chk($sformatf("cont%0d rdata", j), ar[j], exp_d[j]);
    end
    repeat (2) @(posedge clk);
    #1;

    // Stray m_valid while idle.
    stray_d = 32'h12345678; stray_v = 1'b1;
    @(posedge clk); #1;
    stray_v = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) acks++;
    end
    chk("stray no_ack", acks, 0);
    chk("stray i_rdata", bus.i_rdata, 32'hDEADBEEF);
    chk("stray d_rdata", bus.d_rdata, 32'h00BB00DD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
